adc_jesd204_chan_pack: RTL and testbench
========================================

ADC_JESD204_CHAN_PACK -- requirements
Module: adc_jesd204_chan_pack

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: channels at the input, legal values 1, 2, 4.
REQ-002 SHALL have parameter DATA_PATH_WIDTH, default 4: 16-bit samples per channel per beat.
REQ-003 SHALL have port adc_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port adc_rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port adc_enable, input, NUM_CHANNELS bits: per-channel enable from the ADC core.
REQ-006 SHALL have port adc_valid, input, NUM_CHANNELS bits: per-channel beat valid.
REQ-007 SHALL have port adc_data, input, DATA_PATH_WIDTH*NUM_CHANNELS*16 bits: channel c occupies slice c; sample s is bits [16s+15:16s] within the slice.
REQ-008 SHALL have port adc_sync, input, 1 bit: packing start qualifier (see Configuration).
REQ-009 SHALL have port packed_full, input, 1 bit: downstream FIFO full.
REQ-010 SHALL have port packed_valid, output, 1 bit: packed word strobe.
REQ-011 SHALL have port packed_data, output, same width as adc_data: packed word.
REQ-012 SHALL have port packed_ovf, output, 1 bit: one-cycle pulse per dropped word.
REQ-013 SHALL have port packed_err, output, 1 bit: level, high while the enable count is unsupported.

Function
REQ-014 SHALL compute K = popcount(adc_enable); K in {1,2,4} and K<=NUM_CHANNELS is supported, any other value (0, 3) is unsupported.
REQ-015 Beat valid SHALL be the OR of adc_valid over enabled channels.
REQ-016 Fragment per valid beat SHALL be: for s=0..DATA_PATH_WIDTH-1, for each enabled channel in ascending index, its sample s, first item in the LSBs; width K*DATA_PATH_WIDTH*16.
REQ-017 The word SHALL be NUM_CHANNELS/K fragments, first fragment in the LSBs; a beat counter 0..NUM_CHANNELS/K-1 selects the fragment position.
REQ-018 States SHALL be IDLE, WAIT_SYNC and PACK.
REQ-019 IDLE (unsupported K) SHALL produce no output, hold packed_err=1, counter=0; when K becomes supported, go to WAIT_SYNC.
REQ-020 WAIT_SYNC SHALL go to PACK per REQ-030/031; the beat that causes the transition is packed as fragment 0.
REQ-021 In PACK, on the beat completing a word, next cycle: packed_valid=1 and packed_data=word if packed_full=0, else packed_valid=0 and packed_ovf=1; the counter wraps to 0 either way. Latency: 1 cycle from the completing beat.
REQ-022 Any change of adc_enable SHALL discard the partial word, clear the counter, and re-enter IDLE or WAIT_SYNC per the new K, in the same cycle as the change.
REQ-023 Invalid beats SHALL not advance the counter; gaps are allowed between beats of one word.
REQ-024 packed_data SHALL hold its last value when packed_valid=0.
REQ-025 When K=NUM_CHANNELS, each valid beat SHALL emit one word equal to adc_data reordered per REQ-016.

Reset
REQ-026 adc_rstn low SHALL asynchronously force: state IDLE, counter 0, packed_valid 0, packed_ovf 0, packed_data 0, packed_err 0.
REQ-027 The partial word SHALL be discarded on reset mid-word, and no packed_valid SHALL be issued for it after release.
REQ-028 After release, packed_err SHALL reflect K from the first clock edge.

Configuration
REQ-029 Macro ADC_JESD204_CHAN_PACK_SYNC_EN SHALL select sync-qualified start.
REQ-030 With the macro defined, WAIT_SYNC SHALL wait for a valid beat with adc_sync=1.
REQ-031 Without the macro, adc_sync SHALL be ignored and WAIT_SYNC SHALL exit on the first valid beat.

Verification (NUM_CHANNELS=4, DATA_PATH_WIDTH=4, sample value = 16'h0CS0 for channel C, sample S)
REQ-032 enable=4'b1111, one valid beat -> packed_valid for 1 cycle, 1 cycle later; packed_data 16-bit items in order 0000,0100,0200,0300,0010,...,0330.
REQ-033 enable=4'b0101, two valid beats with a 3-cycle gap -> one word after the 2nd beat; items 0000,0200,0010,0210,...,0230, then the 2nd beat's items.
REQ-034 enable=4'b0111 -> packed_err=1, no packed_valid for 20 beats; switch to 4'b0001 -> packed_err=0, one word per 4 beats.
REQ-035 enable=4'b0001, packed_full=1 on the 4th beat -> packed_ovf pulse, no packed_valid; the next 4 beats yield a normal word.
REQ-036 enable=4'b0011, adc_rstn low after 1 beat, then released -> no output until 2 further beats; with the macro, no output until a beat with adc_sync=1.

Source files
------------

// File: rtl/adc_jesd204_chan_pack.sv
// Packs the enabled ADC channels into full-width words, one fragment per valid beat.
// Define ADC_JESD204_CHAN_PACK_SYNC_EN to require adc_sync on the beat that starts packing.
module adc_jesd204_chan_pack #(
  parameter int NUM_CHANNELS    = 4,
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                                      adc_clk,
  input  logic                                      adc_rstn,
  input  logic [NUM_CHANNELS-1:0]                   adc_enable,
  input  logic [NUM_CHANNELS-1:0]                   adc_valid,
  input  logic [DATA_PATH_WIDTH*NUM_CHANNELS*16-1:0] adc_data,
  input  logic                                      adc_sync,
  input  logic                                      packed_full,
  output logic                                      packed_valid,
  output logic [DATA_PATH_WIDTH*NUM_CHANNELS*16-1:0] packed_data,
  output logic                                      packed_ovf,
  output logic                                      packed_err
);

  localparam int unsigned ITEMS = NUM_CHANNELS * DATA_PATH_WIDTH;
  localparam int unsigned WIDTH = ITEMS * 16;
  localparam int unsigned CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_PACK
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [NUM_CHANNELS-1:0] r_enable;
  logic [WIDTH-1:0]        r_word;
  logic [WIDTH-1:0]        w_word;
  logic                    r_packed_valid;
  logic                    r_packed_ovf;
  logic                    r_packed_err;
  logic [WIDTH-1:0]        r_packed_data;

  int unsigned             w_k;
  int unsigned             w_frags;
  logic                    w_sup;
  logic                    w_beat;
  logic                    w_start;
  logic                    w_chg;
  logic                    w_last;
  logic                    w_take;
  logic                    w_emit;

  always_comb begin
    w_k     = $countones(adc_enable);
    w_sup   = ((w_k == 1) || (w_k == 2) || (w_k == 4)) && (w_k <= NUM_CHANNELS);
    w_frags = (w_k == 4) ? (NUM_CHANNELS >> 2) :
              (w_k == 2) ? (NUM_CHANNELS >> 1) : NUM_CHANNELS;
    w_last  = (32'(r_cnt) == (w_frags - 1));
    w_beat  = |(adc_valid & adc_enable);
    w_chg   = (adc_enable != r_enable);
  end

`ifdef ADC_JESD204_CHAN_PACK_SYNC_EN
  assign w_start = w_beat & adc_sync;
`else
  // adc_sync is deliberately a no-op in this build
  assign w_start = w_beat & (adc_sync | 1'b1);
`endif

  // Item index in the word: fragment*K*DPW + sample*K + rank among enabled channels
  always_comb begin
    int unsigned rank;
    int unsigned idx;
    w_word = r_word;
    rank   = 0;
    idx    = 0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (adc_enable[c]) begin
        for (int unsigned s = 0; s < DATA_PATH_WIDTH; s++) begin
          idx = 32'(r_cnt) * w_k * DATA_PATH_WIDTH + s * w_k + rank;
          if (idx < ITEMS) begin
            w_word[idx*16 +: 16] = adc_data[(c*DATA_PATH_WIDTH + s)*16 +: 16];
          end
        end
        rank = rank + 1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_emit      = 1'b0;
    if (w_chg) begin
      w_state_nxt = w_sup ? ST_WAIT_SYNC : ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (w_sup) w_state_nxt = ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC: begin
          if (!w_sup) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_start) begin
            w_state_nxt = ST_PACK;
            w_take      = 1'b1;
            w_emit      = w_last;
            w_cnt_nxt   = w_last ? '0 : r_cnt + CW'(1);
          end
        end
        ST_PACK: begin
          if (!w_sup) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_beat) begin
            w_take    = 1'b1;
            w_emit    = w_last;
            w_cnt_nxt = w_last ? '0 : r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_enable       <= '0;
      r_word         <= '0;
      r_packed_valid <= 1'b0;
      r_packed_ovf   <= 1'b0;
      r_packed_err   <= 1'b0;
      r_packed_data  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_enable       <= adc_enable;
      r_packed_err   <= !w_sup;
      r_packed_valid <= w_emit & !packed_full;
      r_packed_ovf   <= w_emit & packed_full;
      if (w_take) r_word <= w_word;
      if (w_emit && !packed_full) r_packed_data <= w_word;
    end
  end

  assign packed_valid = r_packed_valid;
  assign packed_ovf   = r_packed_ovf;
  assign packed_err   = r_packed_err;
  assign packed_data  = r_packed_data;

endmodule

// File: tb/tb_adc_jesd204_chan_pack.sv
// Self-checking bench for adc_jesd204_chan_pack (4 channels, 4 samples/beat) with a queue-based reference model.
module tb_adc_jesd204_chan_pack;

  localparam int NCH = 4;
  localparam int DPW = 4;
  localparam int W   = NCH * DPW * 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NCH-1:0] en;
  logic [NCH-1:0] vld;
  logic [W-1:0]   data;
  logic           sync;
  logic           full;
  logic           packed_valid;
  logic [W-1:0]   packed_data;
  logic           packed_ovf;
  logic           packed_err;

  adc_jesd204_chan_pack #(.NUM_CHANNELS(NCH), .DATA_PATH_WIDTH(DPW)) dut (
    .adc_clk     (clk),
    .adc_rstn    (rstn),
    .adc_enable  (en),
    .adc_valid   (vld),
    .adc_data    (data),
    .adc_sync    (sync),
    .packed_full (full),
    .packed_valid(packed_valid),
    .packed_data (packed_data),
    .packed_ovf  (packed_ovf),
    .packed_err  (packed_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of 16-bit items collected since the word started
  logic [15:0]    q[$];
  logic [W-1:0]   last_word;
  logic           exp_valid, exp_ovf, exp_err;
  logic [NCH-1:0] prev_en;
  bit             ready, started;

  function automatic void model_reset();
    q.delete();
    last_word = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_err   = 1'b0;
    prev_en   = '0;
    ready     = 0;
    started   = 0;
  endfunction

  function automatic void model_edge();
    int k;
    bit sup, beat, sync_ok;
    logic [W-1:0] word;
    k    = $countones(en);
    sup  = (k == 1) || (k == 2) || (k == 4);
    beat = |(vld & en);
`ifdef ADC_JESD204_CHAN_PACK_SYNC_EN
    sync_ok = (sync === 1'b1);
`else
    sync_ok = 1;
`endif
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    if ((en != prev_en) || !sup) begin
      q.delete();
      ready   = sup;
      started = 0;
    end else if (ready && beat && (started || sync_ok)) begin
      started = 1;
      for (int s = 0; s < DPW; s++)
        for (int c = 0; c < NCH; c++)
          if (en[c]) q.push_back(data[(c*DPW + s)*16 +: 16]);
      if (q.size() == NCH*DPW) begin
        word = '0;
        for (int j = 0; j < NCH*DPW; j++) word[j*16 +: 16] = q[j];
        if (full) exp_ovf = 1'b1;
        else begin
          exp_valid = 1'b1;
          last_word = word;
        end
        q.delete();
      end
    end
    exp_err = !sup;
    prev_en = en;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", W'(packed_valid), W'(exp_valid));
    chk("ovf",   W'(packed_ovf),   W'(exp_ovf));
    chk("err",   W'(packed_err),   W'(exp_err));
    chk("data",  packed_data,      last_word);
  endtask

  task automatic set_pattern();
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < DPW; s++)
        data[(c*DPW + s)*16 +: 16] = 16'((c << 8) | (s << 4));
  endtask

  task automatic set_random();
    for (int i = 0; i < W/32; i++) data[i*32 +: 32] = $urandom;
  endtask

  task automatic change_en(input logic [NCH-1:0] e);
    en  = e;
    vld = '0;
    step();
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    vld  = '0;
    #2;
    model_reset();
    chk("rst_valid", W'(packed_valid), '0);
    chk("rst_ovf",   W'(packed_ovf),   '0);
    chk("rst_err",   W'(packed_err),   '0);
    chk("rst_data",  packed_data,      '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_w;
    rstn = 1'b1;
    en   = '0;
    vld  = '0;
    data = '0;
    sync = 1'b1;
    full = 1'b0;
    #1;
    apply_reset();

    // Full-width enable: one beat gives one word, reordered sample-major
    change_en(4'b1111);
    set_pattern();
    vld = 4'b1111;
    step();
    exp_w = '0;
    for (int j = 0; j < 16; j++) exp_w[j*16 +: 16] = 16'(((j % 4) << 8) | ((j / 4) << 4));
    chk("full_en_valid", W'(packed_valid), W'(1));
    chk("full_en_word", packed_data, exp_w);
    vld = '0;
    step();
    for (int i = 0; i < 6; i++) begin
      vld = 4'($urandom_range(0, 15));
      set_random();
      step();
    end

    // Two channels with a gap between the two beats of a word
    change_en(4'b0101);
    set_pattern();
    vld = 4'b0101;
    step();
    vld = '0;
    repeat (3) step();
    vld = 4'b0101;
    step();
    exp_w = '0;
    for (int j = 0; j < 16; j++) exp_w[j*16 +: 16] = 16'((((j % 2) * 2) << 8) | (((j % 8) / 2) << 4));
    chk("two_ch_valid", W'(packed_valid), W'(1));
    chk("two_ch_word", packed_data, exp_w);
    vld = '0;
    step();

    // Unsupported count of three, then a single channel
    change_en(4'b0111);
    for (int i = 0; i < 20; i++) begin
      vld = 4'b0111;
      set_random();
      step();
    end
    chk("k3_err", W'(packed_err), W'(1));
    change_en(4'b0001);
    chk("k1_err", W'(packed_err), W'(0));
    for (int i = 0; i < 8; i++) begin
      vld = 4'b0001;
      set_random();
      step();
    end

    // Overflow on the completing beat, then a normal word
    change_en(4'b0010);
    change_en(4'b0001);
    for (int i = 0; i < 4; i++) begin
      vld  = 4'b0001;
      full = (i == 3);
      set_random();
      step();
    end
    chk("ovf_pulse", W'(packed_ovf), W'(1));
    chk("ovf_no_valid", W'(packed_valid), W'(0));
    full = 1'b0;
    vld  = '0;
    step();
    chk("ovf_one_cycle", W'(packed_ovf), W'(0));
    for (int i = 0; i < 4; i++) begin
      vld = 4'b0001;
      set_random();
      step();
    end
    chk("after_ovf_valid", W'(packed_valid), W'(1));

    // Reset mid-word discards the partial word
    change_en(4'b0011);
    vld = 4'b0011;
    set_random();
    step();
    apply_reset();
    vld = '0;
    step();
    vld = 4'b0011;
    set_random();
    step();
    chk("rst_mid_no_valid", W'(packed_valid), W'(0));
    set_random();
    step();
    chk("rst_mid_word", W'(packed_valid), W'(1));
    vld = '0;
    step();

    // Randomized traffic with occasional enable changes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        change_en(4'($urandom_range(0, 15)));
      end else begin
        vld  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        full = ($urandom_range(0, 7) == 0);
        sync = ($urandom_range(0, 1) == 1);
        set_random();
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
